// File: rtl/zx_raster_gen.sv
// zx_raster_gen: raster timing generator (hc/vc, blank, sync, INT, flash) for four machine profiles.
// Define ZX_RASTER_INT_EN to add the programmable raster-line interrupt.
module zx_raster_gen #(
    parameter int HC_W     = 9,
    parameter int VC_W     = 9,
    parameter int INT_LEN  = 32,
    parameter int FLASH_W  = 5,
    parameter int C_HTOTAL = 448,
    parameter int C_VTOTAL = 312,
    parameter int C_HBS    = 312,
    parameter int C_HBE    = 416,
    parameter int C_HSS    = 336,
    parameter int C_HSE    = 368,
    parameter int C_VSS    = 240,
    parameter int C_VSE    = 244,
    parameter int C_INTV   = 248,
    parameter int C_INTH   = 2,
    parameter int RINT_HC  = 0
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            ce_7mp,
    input  logic            ce_7mn,
    input  logic [1:0]      mode,
    output logic [HC_W-1:0] hc,
    output logic [VC_W-1:0] vc,
    output logic            border,
    output logic            hblank,
    output logic            hsync,
    output logic            vsync,
    output logic            nINT,
    output logic            flash,
    output logic            frame_start,
    input  logic [VC_W-1:0] rint_line,
    input  logic            rint_en,
    input  logic            rint_ack,
    output logic            rint_pend
);
    // Profile order: Pentagon, ZX48, ZX128, custom
    localparam int HTOT[4] = '{448, 448, 456, C_HTOTAL};
    localparam int VTOT[4] = '{320, 312, 311, C_VTOTAL};
    localparam int HBS[4]  = '{312, 312, 312, C_HBS};
    localparam int HBE[4]  = '{420, 416, 424, C_HBE};
    localparam int HSS[4]  = '{338, 336, 340, C_HSS};
    localparam int HSE[4]  = '{370, 368, 372, C_HSE};
    localparam int VSS[4]  = '{248, 240, 240, C_VSS};
    localparam int VSE[4]  = '{256, 244, 244, C_VSE};
    localparam int INTV[4] = '{239, 248, 248, C_INTV};
    localparam int INTH[4] = '{324, 2, 6, C_INTH};

    logic [1:0]         prof;
    logic [HC_W-1:0]    htotal_m1, hbs, hbe, hss, hse, inth;
    logic [VC_W-1:0]    vtotal_m1, vss, vse, intv;
    logic               line_end, frame_end;
    logic [FLASH_W-1:0] flash_cnt;
    logic [7:0]         int_cnt;

    assign htotal_m1 = HC_W'(HTOT[prof] - 1);
    assign vtotal_m1 = VC_W'(VTOT[prof] - 1);
    assign hbs       = HC_W'(HBS[prof]);
    assign hbe       = HC_W'(HBE[prof]);
    assign hss       = HC_W'(HSS[prof]);
    assign hse       = HC_W'(HSE[prof]);
    assign vss       = VC_W'(VSS[prof]);
    assign vse       = VC_W'(VSE[prof]);
    assign intv      = VC_W'(INTV[prof]);
    assign inth      = HC_W'(INTH[prof]);

    assign line_end  = hc == htotal_m1;
    assign frame_end = line_end & (vc == vtotal_m1);
    assign border    = (vc >= VC_W'(192)) | (hc >= HC_W'(256));
    assign flash     = flash_cnt[FLASH_W-1];

    // The profile only changes at frame wrap, so the counters never exceed the new totals
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            flash_cnt   <= '0;
            frame_start <= 1'b0;
            prof        <= mode;
        end else begin
            frame_start <= ce_7mp & frame_end;
            if (ce_7mp) begin
                hc <= line_end ? '0 : hc + 1'b1;
                if (line_end)
                    vc <= frame_end ? '0 : vc + 1'b1;
                if (frame_end) begin
                    flash_cnt <= flash_cnt + 1'b1;
                    prof      <= mode;
                end
            end
        end
    end

    // Strobes and INT sample the counters before any same-cycle ce_7mp update
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hblank  <= 1'b1;
            hsync   <= 1'b0;
            vsync   <= 1'b0;
            int_cnt <= '0;
        end else if (ce_7mn) begin
            hblank  <= (hc == hbs) | (hblank & (hc != hbe));
            hsync   <= (hc == hss) | (hsync & (hc != hse));
            vsync   <= (vc == vss) | (vsync & (vc != vse));
            int_cnt <= (int_cnt != '0) ? int_cnt - 1'b1 :
                       ((vc == intv) & (hc == inth)) ? 8'(INT_LEN) : 8'd0;
        end
    end

`ifdef ZX_RASTER_INT_EN
    logic rint_hit;
    assign rint_hit = ce_7mn & rint_en & (vc == rint_line) & (hc == HC_W'(RINT_HC));
    always_ff @(posedge clk_sys) begin
        if (reset)
            rint_pend <= 1'b0;
        else
            rint_pend <= rint_hit | (rint_pend & ~rint_ack);
    end
    assign nINT = ~((int_cnt != '0) | rint_pend);
`else
    logic unused_rint;
    assign unused_rint = ^{rint_line, rint_en, rint_ack};
    assign rint_pend   = 1'b0;
    assign nINT        = int_cnt == '0;
`endif
endmodule

// File: tb/tb_zx_raster_gen.sv
// tb_zx_raster_gen: randomized ce stimulus against a position-based raster model with a scoreboard.
module tb_zx_raster_gen;
    localparam int HC_W = 9, VC_W = 9, INT_LEN = 32, FLASH_W = 5, RINT_HC = 0;
    localparam int CH = 32, CV = 20;
    localparam int HT[4]  = '{448, 448, 456, CH};
    localparam int VT[4]  = '{320, 312, 311, CV};
    localparam int HBS[4] = '{312, 312, 312, 20};
    localparam int HBE[4] = '{420, 416, 424, 28};
    localparam int HSS[4] = '{338, 336, 340, 22};
    localparam int HSE[4] = '{370, 368, 372, 26};
    localparam int VSS[4] = '{248, 240, 240, 12};
    localparam int VSE[4] = '{256, 244, 244, 14};
    localparam int IV[4]  = '{239, 248, 248, 15};
    localparam int IH[4]  = '{324, 2, 6, 2};

    logic            clk_sys, reset, ce_7mp, ce_7mn;
    logic [1:0]      mode;
    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc, rint_line;
    logic            border, hblank, hsync, vsync, nINT, flash, frame_start;
    logic            rint_en, rint_ack, rint_pend;

    zx_raster_gen #(
        .HC_W(HC_W), .VC_W(VC_W), .INT_LEN(INT_LEN), .FLASH_W(FLASH_W),
        .C_HTOTAL(CH), .C_VTOTAL(CV), .C_HBS(20), .C_HBE(28), .C_HSS(22), .C_HSE(26),
        .C_VSS(12), .C_VSE(14), .C_INTV(15), .C_INTH(2), .RINT_HC(RINT_HC)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ce_7mp(ce_7mp), .ce_7mn(ce_7mn), .mode(mode),
        .hc(hc), .vc(vc), .border(border), .hblank(hblank), .hsync(hsync), .vsync(vsync),
        .nINT(nINT), .flash(flash), .frame_start(frame_start), .rint_line(rint_line),
        .rint_en(rint_en), .rint_ack(rint_ack), .rint_pend(rint_pend)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int   hc, vc;
        logic border, hblank, hsync, vsync, nint, flash, fs, rp;
    } exp_t;
    exp_t sb[$];

    int checks = 0, fails = 0;
    int m_prof = 0, pos = 0, frames = 0, ncnt = 0, int_until = 0;
    logic hb = 1'b1, hs = 1'b0, vs = 1'b0, fs = 1'b0, rp = 1'b0, ack_rand = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk_sys);
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("hc", 32'(hc), e.hc);
            chk("vc", 32'(vc), e.vc);
            chk("border", 32'(border), 32'(e.border));
            chk("hblank", 32'(hblank), 32'(e.hblank));
            chk("hsync", 32'(hsync), 32'(e.hsync));
            chk("vsync", 32'(vsync), 32'(e.vsync));
            chk("nINT", 32'(nINT), 32'(e.nint));
            chk("flash", 32'(flash), 32'(e.flash));
            chk("frame_start", 32'(frame_start), 32'(e.fs));
            chk("rint_pend", 32'(rint_pend), 32'(e.rp));
        end
    end

    // Model tracks the linear pixel position in the frame; hc/vc are derived from it
    task automatic step(input logic p, input logic n);
        exp_t e;
        int h, v;
        ce_7mp   = p;
        ce_7mn   = n;
        rint_ack = ack_rand && ($urandom_range(0, 3) == 0);
        if (reset) begin
            pos = 0; m_prof = int'(mode); frames = 0;
            hb = 1'b1; hs = 1'b0; vs = 1'b0; fs = 1'b0; rp = 1'b0;
            int_until = ncnt;
        end else begin
            h = pos % HT[m_prof];
            v = pos / HT[m_prof];
            if (n) begin
                if (h == HBS[m_prof]) hb = 1'b1; else if (h == HBE[m_prof]) hb = 1'b0;
                if (h == HSS[m_prof]) hs = 1'b1; else if (h == HSE[m_prof]) hs = 1'b0;
                if (v == VSS[m_prof]) vs = 1'b1; else if (v == VSE[m_prof]) vs = 1'b0;
                if (v == IV[m_prof] && h == IH[m_prof] && ncnt >= int_until)
                    int_until = ncnt + 1 + INT_LEN;
                ncnt++;
            end
`ifdef ZX_RASTER_INT_EN
            if (n && rint_en && v == int'(rint_line) && h == RINT_HC) rp = 1'b1;
            else if (rint_ack) rp = 1'b0;
`endif
            fs = 1'b0;
            if (p) begin
                pos++;
                if (pos == HT[m_prof] * VT[m_prof]) begin
                    pos = 0; frames++; m_prof = int'(mode); fs = 1'b1;
                end
            end
        end
        e.hc     = pos % HT[m_prof];
        e.vc     = pos / HT[m_prof];
        e.border = (e.vc >= 192) || (e.hc >= 256);
        e.hblank = hb;
        e.hsync  = hs;
        e.vsync  = vs;
        e.rp     = rp;
        e.nint   = !((ncnt < int_until) || rp);
        e.flash  = ((frames >> (FLASH_W - 1)) & 1) != 0;
        e.fs     = fs;
        @(posedge clk_sys);
        sb.push_back(e);
        #1;
    endtask

    // One pixel: ce_7mn always sees each hc once, ce_7mp advances it, with random spacing
    task automatic pixel();
        case ($urandom_range(0, 3))
            0: step(1'b1, 1'b1);
            1: begin step(1'b0, 1'b1); step(1'b1, 1'b0); end
            2: begin step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b1, 1'b0); end
            default: begin step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b1, 1'b0); end
        endcase
    endtask

    initial begin
        reset = 1'b1; mode = 2'd1; ce_7mp = 1'b0; ce_7mn = 1'b0;
        rint_en = 1'b0; rint_line = '0; rint_ack = 1'b0;
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        reset = 1'b0;
        repeat (448 * 3 + 10) pixel();
        reset = 1'b1; mode = 2'd2; step(1'b0, 1'b0); reset = 1'b0;
        repeat (456 * 3 + 10) pixel();
        reset = 1'b1; mode = 2'd0; step(1'b0, 1'b0); reset = 1'b0;
        repeat (448 * 2 + 10) pixel();
        reset = 1'b1; mode = 2'd3; step(1'b0, 1'b0); reset = 1'b0;
        ack_rand = 1'b1;
        for (int f = 0; f < 18; f++) begin
            rint_line = VC_W'($urandom_range(0, CV + 3));
            rint_en   = $urandom_range(0, 3) != 0;
            repeat (CH * CV) pixel();
        end
        repeat (CH * 5) pixel();
        mode = 2'd1;
        repeat (CH * CV) pixel();
        repeat (500) pixel();
        mode = 2'd3;
        reset = 1'b1; step(1'b1, 1'b1); reset = 1'b0;
        repeat (CH * 8) pixel();
        reset = 1'b1; step(1'b0, 1'b0); reset = 1'b0;
        repeat (CH * CV * 2) pixel();
        ce_7mp = 1'b0; ce_7mn = 1'b0; ack_rand = 1'b0; rint_ack = 1'b0;
        @(negedge clk_sys);
        @(posedge clk_sys);
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/zx_raster_gen.md
Name: zx_raster_gen

Overview:
- Parametrised raster timing generator for the Spectrum core; successor to the fixed-timing counter logic inside the video controller.
- Generates the horizontal and vertical counters, the blank and sync strobes, the frame interrupt and the flash counter for four selectable machine profiles:
  - Pentagon
  - ZX48
  - ZX128
  - a parameter-defined custom profile
- Adds frame-synchronous profile switching, a configurable interrupt length and an optional programmable raster-line interrupt.
- Sits between the clock-enable generator and the pixel/VRAM fetch logic, which consume hc, vc and border.

Parameters:
HC_W, 9, width of hc.
VC_W, 9, width of vc.
INT_LEN, 32, frame INT length in ce_7mn cycles; legal range 1..255.
FLASH_W, 5, flash counter width; flash output is the counter MSB.
C_HTOTAL, 448, custom profile: pixels per line.
C_VTOTAL, 312, custom profile: lines per frame.
C_HBS, 312, custom profile: hblank start hc. C_HBE, 416, custom profile: hblank end hc.
C_HSS, 336, custom profile: hsync start hc. C_HSE, 368, custom profile: hsync end hc.
C_VSS, 240, custom profile: vsync start vc. C_VSE, 244, custom profile: vsync end vc.
C_INTV, 248, custom profile: INT line. C_INTH, 2, custom profile: INT hc.
RINT_HC, 0, hc at which the raster interrupt fires.

Ports:
clk_sys  in  1  master clock; the only clock.
reset  in  1  synchronous reset, active-high.
ce_7mp  in  1  pixel clock enable, positive phase.
ce_7mn  in  1  pixel clock enable, negative phase.
mode  in  2  profile select: 0 Pentagon, 1 ZX48, 2 ZX128, 3 custom.
hc  out  HC_W  horizontal counter.
vc  out  VC_W  vertical counter.
border  out  1  high when outside the 256x192 active area.
hblank  out  1  horizontal blank.
hsync  out  1  horizontal sync, active-high.
vsync  out  1  vertical sync, active-high.
nINT  out  1  CPU interrupt, active-low.
flash  out  1  flash phase.
frame_start  out  1  one clk_sys pulse at frame wrap.
rint_line  in  VC_W  raster interrupt line.
rint_en  in  1  raster interrupt enable.
rint_ack  in  1  clears a pending raster interrupt.
rint_pend  out  1  raster interrupt pending.

Behaviour:

Clock and reset:
- Single clock clk_sys; reset is synchronous and active-high.
- Reset values: hc=0, vc=0, hblank=1, hsync=0, vsync=0, nINT=1, flash counter=0, frame_start=0, rint_pend=0, INT counter=0.
- On reset, the active profile register prof is loaded from mode.

Profile timing table (HTOTAL, VTOTAL, HB start..end, HS start..end, VS start..end, INT vc/hc):
- Pentagon: 448, 320, 312..420, 338..370, 248..256, 239/324.
- ZX48: 448, 312, 312..416, 336..368, 240..244, 248/2.
- ZX128: 456, 311, 312..424, 340..372, 240..244, 248/6.
- Custom: the C_* parameters.

Counters (on ce_7mp):
- At hc==HTOTAL-1, hc goes to 0; otherwise hc increments.
- On each line wrap, vc increments. At vc==VTOTAL-1 with a line wrap, vc goes to 0.
- On frame wrap:
  - the flash counter increments (wraps naturally);
  - frame_start pulses for exactly one clk_sys cycle;
  - prof is loaded from mode.
- A mode change mid-frame has no effect until that wrap, so hc/vc can never exceed the new totals.

Strobes (on ce_7mn, compared against the registered hc/vc):
- hblank: set at hc==HB start, cleared at hc==HB end.
- hsync: set at hc==HS start, cleared at hc==HS end.
- vsync: set at vc==VS start, cleared at vc==VS end. It may toggle on any ce_7mn during that line.
- border = (vc>=192) | (hc>=256), combinational from the counters.

Frame INT:
- Triggered on ce_7mn when vc==INT vc and hc==INT hc.
- nINT is then held low for exactly INT_LEN ce_7mn cycles.
- A retrigger while active is ignored; the length is not extended.

Simultaneous ce_7mp and ce_7mn:
- Each is processed on its own.
- ce_7mn compares use the pre-update hc/vc values.

Optional Feature:
Macro: ZX_RASTER_INT_EN.

With the macro defined:
- On ce_7mn, when rint_en=1, vc==rint_line and hc==RINT_HC, rint_pend is set.
- rint_ack=1 clears rint_pend. If a set and an ack occur in the same cycle, the set wins.
- nINT = ~(frame_int_active | rint_pend).
- rint_line >= VTOTAL never fires.
- Dropping rint_en does not clear a pending interrupt.

Without the macro:
- The rint_* input ports still exist but are ignored.
- rint_pend is tied to 0.
- nINT reflects the frame INT only.

Test Plan:
- Reset with mode=1, then run one frame of ce_7mp/ce_7mn -> 448 hc values per line; vc wraps 311->0; exactly one frame_start pulse; nINT low for 32 ce_7mn cycles starting at vc=248, hc=2.
- mode=2 -> hc wraps 455->0 and vc wraps 310->0; hsync high from hc=340 to hc=372; nINT falls at vc=248, hc=6.
- Switch mode 1->0 at vc=100 -> timing stays ZX48 until the wrap at vc=311; the next frame has 320 lines and INT at vc=239, hc=324.
- Run 16 frames -> flash toggles after frame 16 (FLASH_W=5). Assert reset at vc=150 -> on the next clock hc=0, vc=0, hblank=1, nINT=1.
- With ZX_RASTER_INT_EN, rint_en=1, rint_line=100 -> rint_pend rises at vc=100, hc=0 and nINT goes low; rint_ack pulsed at vc=101 -> rint_pend and nINT return high. Ack pulsed in the same cycle as a set -> rint_pend stays 1.
- Without the macro, with the same stimulus as the previous scenario -> rint_pend stays 0 and nINT only goes low for the frame INT.
